gcd_arbiter: RTL and testbench

Round-robin arbiter that shares one GCD core (`toplevel` datapath + IDLE/COMPUTE/DONE control) among N_REQ requesters. It accepts operand pairs over per-requester req/grant handshakes and issues one pair at a time to the core. It returns each result to its owner over a valid/taken handshake. A watchdog aborts computations that exceed TIMEOUT cycles. It sits between the requester fabric and the single core instance.

---
 rtl/gcd_arbiter_pkg.sv | 25 ++
 rtl/gcd_rr_picker.sv | 37 +++
 rtl/gcd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arbiter_pkg.sv
// Shared definitions for the GCD arbiter slice: arbiter and core
// state encodings, default operand width, index-width helper.
package gcd_arbiter_pkg;

  localparam int DEF_NUM_OF_BITS = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Core control encodings, shared with the core and benches.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } core_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_rr_picker.sv
// Combinational round-robin pick: first set req bit at/after ptr.
// Ports: req, ptr in; pick (one-hot), idx, any out.
module gcd_rr_picker
  import gcd_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    jj   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any      = 1'b1;
        idx      = jj;
        pick[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD core among N_REQ requesters.
// Ports: Req/Req_A/Req_B/Grant in-side, Rsp_* out-side, Gcd_* core side.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int numOfBits = DEF_NUM_OF_BITS,
  parameter int TIMEOUT   = 64
) (
  input  logic                       Clk,
  input  logic                       nrst,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*numOfBits-1:0] Req_A,
  input  logic [N_REQ*numOfBits-1:0] Req_B,
  output logic [N_REQ-1:0]           Grant,
  output logic [N_REQ-1:0]           Rsp_valid,
  output logic [numOfBits-1:0]       Rsp_data,
  output logic                       Rsp_err,
  input  logic [N_REQ-1:0]           Rsp_taken,
  output logic [numOfBits-1:0]       Gcd_A,
  output logic [numOfBits-1:0]       Gcd_B,
  output logic                       Gcd_In_ready,
  input  logic                       Gcd_Done,
  input  logic [numOfBits-1:0]       Gcd_Result,
  output logic                       Gcd_Result_taken,
  output logic                       Gcd_nrst,
  output logic                       Busy
);

  localparam int W  = numOfBits;
  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [N_REQ-1:0] ONE  = N_REQ'(1);
  localparam logic [CW-1:0]    TLIM = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LAST = IW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [W-1:0]     gcd_a_q, gcd_a_d;
  logic [W-1:0]     gcd_b_q, gcd_b_d;
  logic             in_ready_q, in_ready_d;
  logic             res_taken_q, res_taken_d;
  logic             gcd_nrst_q, gcd_nrst_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             timeout;
  logic             taken_own;

  gcd_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req  (Req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign timeout   = (cnt_q == TLIM);
  assign taken_own = Rsp_taken[owner_q];

  always_ff @(posedge Clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      in_ready_q  <= 1'b0;
      res_taken_q <= 1'b0;
      gcd_nrst_q  <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      in_ready_q  <= in_ready_d;
      res_taken_q <= res_taken_d;
      gcd_nrst_q  <= gcd_nrst_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (Gcd_Done || timeout)
                   state_d = ARB_RESP;
      ARB_RESP:  if (taken_own) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Pulses default low every cycle; data registers hold.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    in_ready_d  = 1'b0;
    res_taken_d = 1'b0;
    gcd_nrst_d  = 1'b1;
    cnt_d       = cnt_q;
    busy_d      = (state_d != ARB_IDLE);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          grant_d = pick;
          gcd_a_d = Req_A[int'(pick_idx)*W +: W];
          gcd_b_d = Req_B[int'(pick_idx)*W +: W];
        end
      end
      ARB_ISSUE: begin
        in_ready_d = 1'b1;
        cnt_d      = '0;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Done takes priority over a same-cycle timeout.
        if (Gcd_Done) begin
          rsp_data_d  = Gcd_Result;
          rsp_err_d   = 1'b0;
          res_taken_d = 1'b1;
          rsp_valid_d = ONE << owner_q;
        end else if (timeout) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          gcd_nrst_d  = 1'b0;
          rsp_valid_d = ONE << owner_q;
        end
      end
      ARB_RESP: begin
        if (taken_own) begin
          rsp_valid_d = '0;
          rsp_err_d   = 1'b0;
          ptr_d = (owner_q == LAST) ? '0
                : owner_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  assign Grant            = grant_q;
  assign Rsp_valid        = rsp_valid_q;
  assign Rsp_data         = rsp_data_q;
  assign Rsp_err          = rsp_err_q;
  assign Gcd_A            = gcd_a_q;
  assign Gcd_B            = gcd_b_q;
  assign Gcd_In_ready     = in_ready_q;
  assign Gcd_Result_taken = res_taken_q;
  assign Gcd_nrst         = gcd_nrst_q;
  assign Busy             = busy_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD core model.
// Expected results are hand-computed constants.
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   grant;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [N-1:0]   rsp_taken;
  logic [W-1:0]   gcd_a;
  logic [W-1:0]   gcd_b;
  logic           in_ready;
  logic           done;
  logic [W-1:0]   result;
  logic           res_taken;
  logic           gcd_nrst;
  logic           busy;

  int checks = 0;
  int errors = 0;

  int core_lat  = 1;
  bit core_hang = 1'b0;

  always #5 clk = ~clk;

  gcd_arbiter #(.N_REQ(N), .numOfBits(W), .TIMEOUT(8)) dut (
    .Clk              (clk),
    .nrst             (nrst),
    .Req              (req),
    .Req_A            (req_a),
    .Req_B            (req_b),
    .Grant            (grant),
    .Rsp_valid        (rsp_valid),
    .Rsp_data         (rsp_data),
    .Rsp_err          (rsp_err),
    .Rsp_taken        (rsp_taken),
    .Gcd_A            (gcd_a),
    .Gcd_B            (gcd_b),
    .Gcd_In_ready     (in_ready),
    .Gcd_Done         (done),
    .Gcd_Result       (result),
    .Gcd_Result_taken (res_taken),
    .Gcd_nrst         (gcd_nrst),
    .Busy             (busy)
  );

  // Behavioural core: result after core_lat cycles, or never when hung.
  function automatic logic [W-1:0] gcd_f(
    input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < 64; i++) begin
      if (y != 0) begin
        t = x % y;
        x = y;
        y = t;
      end
    end
    return x;
  endfunction

  logic core_rst_n;
  int   c_cnt;
  logic c_run;
  assign core_rst_n = nrst & gcd_nrst;

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      done   <= 1'b0;
      c_run  <= 1'b0;
      c_cnt  <= 0;
      result <= '0;
    end else begin
      if (in_ready) begin
        c_run  <= 1'b1;
        c_cnt  <= core_lat;
        result <= gcd_f(gcd_a, gcd_b);
        done   <= 1'b0;
      end else if (c_run && !core_hang) begin
        if (c_cnt == 0) begin
          done  <= 1'b1;
          c_run <= 1'b0;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
      if (res_taken) done <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i,
    input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int n,
    output bit saw_abort);
    ok = 1'b0;
    n = 0;
    saw_abort = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      n++;
      if (!gcd_nrst) saw_abort = 1'b1;
      if (rsp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take(input int i);
    rsp_taken = '0;
    rsp_taken[i] = 1'b1;
    step();
    rsp_taken = '0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req = '0;
    req_a = '0;
    req_b = '0;
    rsp_taken = '0;
    step();
    step();
    checks++;
    if (grant !== '0 || busy !== 1'b0 ||
        rsp_valid !== '0 || rsp_data !== '0 ||
        rsp_err !== 1'b0 || in_ready !== 1'b0 ||
        gcd_nrst !== 1'b1 || res_taken !== 1'b0 ||
        gcd_a !== '0 || gcd_b !== '0) begin
      errors++;
      $display("FAIL reset: grant=%b busy=%b valid=%b nrst=%b",
        grant, busy, rsp_valid, gcd_nrst);
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_d [4] = '{5'd10, 5'd5, 5'd3, 5'd11};
    logic [N-1:0] exp_g;
    bit ok, ab;
    int n;
    set_ops(0, 5'd30, 5'd20);
    set_ops(1, 5'd5, 5'd10);
    set_ops(2, 5'd3, 5'd21);
    set_ops(3, 5'd11, 5'd11);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_g = '0;
      exp_g[k] = 1'b1;
      wait_grant(ok);
      checks++;
      if (!ok || grant !== exp_g) begin
        errors++;
        $display("FAIL contention grant %0d: got %b want %b",
          k, grant, exp_g);
      end
      req[k] = 1'b0;
      wait_rsp(ok, n, ab);
      checks++;
      if (!ok || rsp_valid !== exp_g ||
          rsp_data !== exp_d[k] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL contention rsp %0d: v=%b d=%0d want %0d",
          k, rsp_valid, rsp_data, exp_d[k]);
      end
      take(k);
    end
    req = '0;
  endtask

  task automatic test_single();
    bit ok, ab;
    int n;
    set_ops(0, 5'd6, 5'd3);
    req = 4'b0001;
    wait_grant(ok);
    checks++;
    if (!ok || grant !== 4'b0001 || gcd_a !== 5'd6 ||
        gcd_b !== 5'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single grant: g=%b a=%0d b=%0d busy=%b",
        grant, gcd_a, gcd_b, busy);
    end
    req = '0;
    step();
    checks++;
    if (grant !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single issue: g=%b in_ready=%b want 0/1",
        grant, in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single in_ready width: got %b want 0",
        in_ready);
    end
    wait_rsp(ok, n, ab);
    checks++;
    if (!ok || rsp_valid !== 4'b0001 ||
        rsp_data !== 5'd3 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single rsp: v=%b d=%0d e=%b want 0001/3/0",
        rsp_valid, rsp_data, rsp_err);
    end
    take(1);
    checks++;
    if (rsp_valid !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL foreign taken: v=%b busy=%b want 0001/1",
        rsp_valid, busy);
    end
    take(0);
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single release: v=%b busy=%b want 0/0",
        rsp_valid, busy);
    end
  endtask

  task automatic test_fairness();
    bit ok, ab;
    int n;
    set_ops(1, 5'd8, 5'd12);
    req = 4'b0010;
    wait_grant(ok);
    wait_rsp(ok, n, ab);
    take(1);
    set_ops(0, 5'd9, 5'd6);
    req = 4'b0011;
    wait_grant(ok);
    checks++;
    if (!ok || grant !== 4'b0001) begin
      errors++;
      $display("FAIL fairness first: got %b want 0001", grant);
    end
    req[0] = 1'b0;
    wait_rsp(ok, n, ab);
    checks++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_data !== 5'd3) begin
      errors++;
      $display("FAIL fairness rsp0: v=%b d=%0d want 0001/3",
        rsp_valid, rsp_data);
    end
    take(0);
    wait_grant(ok);
    checks++;
    if (!ok || grant !== 4'b0010) begin
      errors++;
      $display("FAIL fairness second: got %b want 0010", grant);
    end
    req = '0;
    wait_rsp(ok, n, ab);
    checks++;
    if (!ok || rsp_valid !== 4'b0010 || rsp_data !== 5'd4) begin
      errors++;
      $display("FAIL fairness rsp1: v=%b d=%0d want 0010/4",
        rsp_valid, rsp_data);
    end
    take(1);
  endtask

  task automatic test_done_last();
    bit ok, ab;
    int n;
    core_lat = 5;
    set_ops(2, 5'd14, 5'd21);
    req = 4'b0100;
    wait_grant(ok);
    req = '0;
    step();
    wait_rsp(ok, n, ab);
    checks++;
    if (!ok || n != 8 || ab || rsp_valid !== 4'b0100 ||
        rsp_err !== 1'b0 || rsp_data !== 5'd7) begin
      errors++;
      $display("FAIL done_last: n=%0d abort=%b e=%b d=%0d want 8/0/0/7",
        n, ab, rsp_err, rsp_data);
    end
    take(2);
    core_lat = 1;
  endtask

  task automatic test_watchdog();
    bit ok, ab;
    int n;
    core_hang = 1'b1;
    set_ops(3, 5'd6, 5'd4);
    req = 4'b1000;
    wait_grant(ok);
    checks++;
    if (!ok || grant !== 4'b1000) begin
      errors++;
      $display("FAIL watchdog grant: got %b want 1000", grant);
    end
    req = '0;
    step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      if (!gcd_nrst) break;
    end
    checks++;
    if (gcd_nrst !== 1'b0 || n != 8) begin
      errors++;
      $display("FAIL watchdog abort: nrst=%b after %0d want 0/8",
        gcd_nrst, n);
    end
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 ||
        rsp_data !== '0) begin
      errors++;
      $display("FAIL watchdog rsp: v=%b e=%b d=%0d want 1000/1/0",
        rsp_valid, rsp_err, rsp_data);
    end
    step();
    checks++;
    if (gcd_nrst !== 1'b1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL watchdog pulse: nrst=%b e=%b want 1/1",
        gcd_nrst, rsp_err);
    end
    core_hang = 1'b0;
    take(3);
    checks++;
    if (rsp_err !== 1'b0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL watchdog clear: e=%b v=%b want 0/0",
        rsp_err, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ab;
    int n;
    core_lat = 3;
    set_ops(0, 5'd10, 5'd4);
    req = 4'b0001;
    wait_grant(ok);
    req = '0;
    step();
    step();
    nrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== '0 || rsp_valid !== '0 ||
        in_ready !== 1'b0 || gcd_nrst !== 1'b1 ||
        gcd_a !== '0 || gcd_b !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b a=%0d b=%0d nrst=%b",
        busy, gcd_a, gcd_b, gcd_nrst);
    end
    step();
    nrst = 1'b1;
    core_lat = 1;
    step();
    set_ops(3, 5'd4, 5'd2);
    req = 4'b1000;
    wait_grant(ok);
    checks++;
    if (!ok || grant !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid grant: got %b want 1000", grant);
    end
    req = '0;
    wait_rsp(ok, n, ab);
    checks++;
    if (!ok || rsp_valid !== 4'b1000 || rsp_data !== 5'd2) begin
      errors++;
      $display("FAIL reset_mid rsp: v=%b d=%0d want 1000/2",
        rsp_valid, rsp_data);
    end
    take(3);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_done_last();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
